// File: rtl/mac_layer_seq.sv
// rtl/mac_layer_seq.sv - neuron sequencer for one signed 8x8 MAC lane
// Streams image/weight reads per neuron, times accumulator controls, hands results out on valid/ready.
module mac_layer_seq #(
  parameter int IN_LEN  = 784,
  parameter int OUT_LEN = 10,
  parameter int IA_W    = 10,
  parameter int WA_W    = 13,
  parameter int MEM_LAT = 1,
  parameter int MAC_LAT = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            relu_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            img_rd_o,
  output logic [IA_W-1:0] img_addr_o,
  output logic            wgt_rd_o,
  output logic [WA_W-1:0] wgt_addr_o,
  output logic            mac_clear_o,
  output logic            acc_en_o,
  output logic            relu_en_o,
  input  logic [31:0]     mac_result_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [31:0]     res_data_o,
  output logic [3:0]      res_idx_o
);

  localparam int LAT = MEM_LAT + MAC_LAT;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_RELU, S_CAPT, S_OUT, S_DONE
  } state_t;

  state_t          r_state, w_next;
  logic [LAT-1:0]  r_pipe;
  logic [LAT-1:0]  w_pipe_nxt;
  logic            r_relu;
  logic [IA_W-1:0] r_i;
  logic [WA_W-1:0] r_base;
  logic [WA_W-1:0] r_wa;
  logic [3:0]      r_n;
  logic            r_res_valid;
  logic [31:0]     r_res_data;
  logic [3:0]      r_res_idx;
  logic            w_rd;
  logic            w_last_in;
  logic            w_last_n;

  assign w_rd      = (r_state == S_STREAM);
  assign w_last_in = (r_i == IA_W'(IN_LEN - 1));
  assign w_last_n  = (r_n == 4'(OUT_LEN - 1));

  // Read strobe travels the memory+multiplier latency before it becomes acc_en.
  generate
    if (LAT == 1) begin : g_pipe1
      assign w_pipe_nxt = w_rd;
    end else begin : g_pipen
      assign w_pipe_nxt = {r_pipe[LAT-2:0], w_rd};
    end
  endgenerate

  always_comb begin
    w_next      = r_state;
    busy_o      = (r_state != S_IDLE);
    done_o      = 1'b0;
    mac_clear_o = 1'b0;
    relu_en_o   = 1'b0;
    img_rd_o    = w_rd;
    wgt_rd_o    = w_rd;
    img_addr_o  = w_rd ? r_i  : '0;
    wgt_addr_o  = w_rd ? r_wa : '0;
    acc_en_o    = r_pipe[LAT-1];
    case (r_state)
      S_IDLE:   if (start_i) w_next = S_CLEAR;
      S_CLEAR: begin
        mac_clear_o = 1'b1;
        w_next      = S_STREAM;
      end
      S_STREAM: if (w_last_in) w_next = S_DRAIN;
      // Exit once the last strobe is being consumed, so CAPT sees the final sum.
      S_DRAIN:  if (w_pipe_nxt == '0) w_next = r_relu ? S_RELU : S_CAPT;
      S_RELU: begin
        relu_en_o = 1'b1;
        w_next    = S_CAPT;
      end
      S_CAPT:   w_next = S_OUT;
      S_OUT:    if (res_ready_i) w_next = w_last_n ? S_DONE : S_CLEAR;
      S_DONE: begin
        done_o = 1'b1;
        w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_pipe      <= '0;
      r_relu      <= 1'b0;
      r_i         <= '0;
      r_base      <= '0;
      r_wa        <= '0;
      r_n         <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_idx   <= '0;
    end else begin
      r_state <= w_next;
      r_pipe  <= w_pipe_nxt;
      case (r_state)
        S_IDLE: if (start_i) begin
          r_relu <= relu_i;
          r_n    <= '0;
          r_base <= '0;
        end
        S_CLEAR: begin
          r_i  <= '0;
          r_wa <= r_base;
        end
        S_STREAM: begin
          r_i  <= w_last_in ? '0 : r_i + 1'b1;
          r_wa <= r_wa + 1'b1;
        end
        S_CAPT: begin
          r_res_data  <= mac_result_i;
          r_res_idx   <= r_n;
          r_res_valid <= 1'b1;
        end
        S_OUT: if (res_ready_i) begin
          r_res_valid <= 1'b0;
          r_base      <= r_base + WA_W'(IN_LEN);
          r_n         <= r_n + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign res_valid_o = r_res_valid;
  assign res_data_o  = r_res_data;
  assign res_idx_o   = r_res_idx;

endmodule

// File: tb/tb_mac_layer_seq.sv
// tb/tb_mac_layer_seq.sv - scoreboard bench for mac_layer_seq with a behavioural MAC lane and BRAMs
module tb_mac_layer_seq;
  localparam int IN_LEN = 4, OUT_LEN = 2, IA_W = 4, WA_W = 4;
  localparam int NEURON_CYC = 1 + IN_LEN + 3 + 1 + 1;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, relu = 1'b0, res_ready = 1'b1;
  logic busy, done, img_rd, wgt_rd, mac_clear, acc_en, relu_en, res_valid;
  logic [IA_W-1:0] img_addr;
  logic [WA_W-1:0] wgt_addr;
  logic [31:0] mac_result, res_data;
  logic [3:0] res_idx;

  always #5 clk = ~clk;

  mac_layer_seq #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .IA_W(IA_W), .WA_W(WA_W),
                  .MEM_LAT(1), .MAC_LAT(2)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .relu_i(relu), .busy_o(busy), .done_o(done),
    .img_rd_o(img_rd), .img_addr_o(img_addr), .wgt_rd_o(wgt_rd), .wgt_addr_o(wgt_addr),
    .mac_clear_o(mac_clear), .acc_en_o(acc_en), .relu_en_o(relu_en), .mac_result_i(mac_result),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data), .res_idx_o(res_idx));

  // BRAM (1 cycle) -> operand reg -> product reg -> 41b accumulator
  logic signed [7:0]  img_mem [0:15];
  logic signed [7:0]  wgt_mem [0:15];
  logic signed [7:0]  img_q, wgt_q, op_a, op_b;
  logic signed [15:0] prod;
  logic signed [40:0] acc;
  always @(posedge clk) begin
    img_q <= img_mem[img_addr];
    wgt_q <= wgt_mem[wgt_addr];
    op_a  <= img_q;
    op_b  <= wgt_q;
    prod  <= op_a * op_b;
    if (acc_en)         acc <= acc + {{25{prod[15]}}, prod};
    else if (relu_en)   acc <= acc[40] ? '0 : acc;
    else if (mac_clear) acc <= '0;
  end
  assign mac_result = acc[31:0];

  typedef struct { logic [3:0] idx; logic [31:0] data; } exp_t;
  exp_t sb[$];
  int img_log[$];
  int wgt_log[$];
  int tests = 0, fails = 0;
  int done_cnt = 0, busy_cnt = 0, relu_cnt = 0, acc_cnt = 0, onehot_viol = 0, layer_d0 = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (int'(mac_clear) + int'(acc_en) + int'(relu_en) > 1) onehot_viol++;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (relu_en) relu_cnt++;
      if (mac_clear) acc_cnt = 0;
      if (acc_en) acc_cnt++;
      if (img_rd) img_log.push_back(int'(img_addr));
      if (wgt_rd) wgt_log.push_back(int'(wgt_addr));
      if (res_valid && res_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL result_unexpected: got idx=%0d data=%0d, required no result", res_idx, $signed(res_data));
        end else begin
          e = sb.pop_front();
          if (res_idx !== e.idx || res_data !== e.data) begin
            fails++;
            $display("FAIL result: got idx=%0d data=%0d, required idx=%0d data=%0d",
                     res_idx, $signed(res_data), e.idx, $signed(e.data));
          end
          tests++;
          if (acc_cnt !== IN_LEN) begin
            fails++;
            $display("FAIL acc_en_count: got %0d, required %0d", acc_cnt, IN_LEN);
          end
        end
      end
    end
  end

  task automatic set_mem(input int mode);
    for (int a = 0; a < 16; a++) begin
      case (mode)
        0:       begin img_mem[a] = 8'sd1;     wgt_mem[a] = 8'sd1;      end
        1:       begin img_mem[a] = 8'sd3;     wgt_mem[a] = -8'sd2;     end
        default: begin img_mem[a] = 8'(a + 1); wgt_mem[a] = 8'(a - 3);  end
      endcase
    end
  endtask

  task automatic start_layer(input logic r);
    for (int n = 0; n < OUT_LEN; n++) begin
      int s = 0;
      for (int i = 0; i < IN_LEN; i++) s += int'(img_mem[i]) * int'(wgt_mem[n*IN_LEN + i]);
      if (r && s < 0) s = 0;
      sb.push_back('{idx: 4'(n), data: 32'(s)});
    end
    img_log.delete(); wgt_log.delete();
    busy_cnt = 0; relu_cnt = 0; layer_d0 = done_cnt;
    @(posedge clk); #1; start = 1'b1; relu = r;
    @(posedge clk); #1; start = 1'b0; relu = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0 = done_cnt;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_img_addr(input int a, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (img_rd && img_addr == IA_W'(a)) begin ok = 1'b1; break; end
    end
  endtask

  task automatic check_layer(input string name, input int busy_exp, input int relu_exp);
    int bad = 0;
    tests++;
    if (done_cnt - layer_d0 !== 1) begin
      fails++; $display("FAIL %s done_count: got %0d, required 1", name, done_cnt - layer_d0);
    end
    tests++;
    if (busy_cnt !== busy_exp) begin
      fails++; $display("FAIL %s busy_cycles: got %0d, required %0d", name, busy_cnt, busy_exp);
    end
    tests++;
    if (relu_cnt !== relu_exp) begin
      fails++; $display("FAIL %s relu_pulses: got %0d, required %0d", name, relu_cnt, relu_exp);
    end
    tests++;
    if (wgt_log.size() != IN_LEN*OUT_LEN || img_log.size() != IN_LEN*OUT_LEN) bad = 1;
    else for (int k = 0; k < IN_LEN*OUT_LEN; k++)
      if (wgt_log[k] != k || img_log[k] != k % IN_LEN) bad = 1;
    if (bad) begin
      fails++; $display("FAIL %s addr_seq: got %0d img/%0d wgt reads (or wrong order), required %0d in order 0..",
                        name, img_log.size(), wgt_log.size(), IN_LEN*OUT_LEN);
    end
    tests++;
    if (sb.size() !== 0) begin
      fails++; $display("FAIL %s results_missing: got %0d pending, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, img_rd, wgt_rd, mac_clear, acc_en, relu_en, res_valid} !== 8'h00) begin
      fails++; $display("FAIL reset_ctrl: got %b, required 00000000",
                        {busy, done, img_rd, wgt_rd, mac_clear, acc_en, relu_en, res_valid});
    end
    tests++;
    if ({img_addr, wgt_addr, res_data, res_idx} !== '0) begin
      fails++; $display("FAIL reset_data: got addr %0d/%0d data %0d idx %0d, required all 0",
                        img_addr, wgt_addr, res_data, res_idx);
    end
    rst = 1'b0;
  endtask

  task automatic run_and_check(input string name, input int mode, input logic r, input int relu_exp);
    bit ok;
    set_mem(mode);
    start_layer(r);
    wait_done(200, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL %s done_timeout: got no done_o, required one", name); end
    check_layer(name, 2*NEURON_CYC + 1 + (r ? OUT_LEN : 0), relu_exp);
  endtask

  task automatic test_basic();
    run_and_check("basic", 0, 1'b0, 0);
  endtask

  task automatic test_negative();
    run_and_check("neg_norelu", 1, 1'b0, 0);
    run_and_check("neg_relu", 1, 1'b1, OUT_LEN);
  endtask

  task automatic test_pattern();
    run_and_check("pattern_norelu", 2, 1'b0, 0);
    run_and_check("pattern_relu", 2, 1'b1, OUT_LEN);
  endtask

  task automatic test_backpressure();
    bit ok = 1'b0;
    logic [31:0] held;
    logic [3:0]  held_idx;
    set_mem(2);
    res_ready = 1'b0;
    start_layer(1'b0);
    for (int k = 0; k < 100 && !ok; k++) begin
      @(posedge clk); #1;
      if (res_valid) ok = 1'b1;
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL bp_valid_timeout: got no res_valid_o, required one"); end
    held = res_data; held_idx = res_idx;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      tests++;
      if (res_valid !== 1'b1 || res_data !== held || res_idx !== held_idx || img_rd || wgt_rd) begin
        fails++; $display("FAIL bp_hold cycle %0d: got valid=%b data=%0d idx=%0d rd=%b%b, required 1/%0d/%0d/00",
                          k, res_valid, $signed(res_data), res_idx, img_rd, wgt_rd, $signed(held), held_idx);
      end
    end
    res_ready = 1'b1;
    wait_done(200, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL bp_done_timeout: got no done_o, required one"); end
    check_layer("backpressure", 2*NEURON_CYC + 1 + 5, 0);
  endtask

  task automatic test_start_ignored();
    bit ok;
    set_mem(0);
    start_layer(1'b0);
    wait_img_addr(1, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL ign_stream_timeout: got no stream, required img_addr 1"); end
    start = 1'b1; relu = 1'b1;
    @(posedge clk); #1; start = 1'b0; relu = 1'b0;
    wait_done(200, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL ign_done_timeout: got no done_o, required one"); end
    repeat (5) @(posedge clk);
    #1;
    check_layer("start_ignored", 2*NEURON_CYC + 1, 0);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL ign_restart: got busy=%b, required 0", busy); end
  endtask

  task automatic test_reset_abort();
    bit ok;
    int d0;
    set_mem(2);
    start_layer(1'b0);
    wait_img_addr(2, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL abort_stream_timeout: got no stream, required img_addr 2"); end
    rst = 1'b1;
    #1;
    tests++;
    if ({busy, done, img_rd, wgt_rd, mac_clear, acc_en, relu_en, res_valid, img_addr, wgt_addr, res_idx} !== '0) begin
      fails++; $display("FAIL abort_async: got busy=%b rd=%b%b acc=%b addr=%0d/%0d, required all 0",
                        busy, img_rd, wgt_rd, acc_en, img_addr, wgt_addr);
    end
    sb.delete();
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    tests++;
    if (done_cnt !== d0 || busy !== 1'b0) begin
      fails++; $display("FAIL abort_quiet: got done delta %0d busy=%b, required 0/0", done_cnt - d0, busy);
    end
    run_and_check("after_abort", 2, 1'b0, 0);
  endtask

  initial begin
    set_mem(0);
    test_reset();
    test_basic();
    test_negative();
    test_pattern();
    test_backpressure();
    test_start_ignored();
    test_reset_abort();
    tests++;
    if (onehot_viol !== 0) begin
      fails++; $display("FAIL ctrl_onehot: got %0d overlapping cycles, required 0", onehot_viol);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog");
  end

endmodule
